dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-ported data memory between two requesters, the CPU load/store unit and a DMA/debug port, using round-robin or fixed-priority arbitration. Each accepted access is sequenced into one or two aligned word beats on the memory port; the block applies byte enables and lane shifting, and sign/zero-extends load data per func3. Misaligned halfword and word accesses are split into two beats, so the memory itself handles only aligned words with byte enables.

## Interface
- `MEM_AW`, 10, word-index width of the memory port (1024 words).
- `PRIO_CPU`, 0, 1 = CPU always wins ties; 0 = round-robin.
- `clk`  in  1  clock; all state updates on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `cpu_req` / `dma_req`  in  1  request; hold stable with payload until gnt.
- `cpu_we` / `dma_we`  in  1  1 = store, 0 = load.
- `cpu_addr` / `dma_addr`  in  32  byte address; only bits [MEM_AW+1:0] are used.
- `cpu_func3` / `dma_func3`  in  3  access type: 0 b, 1 h, 2 w, 4 bu, 5 hu.
- `cpu_wdata` / `dma_wdata`  in  32  store data, right-aligned.
- `cpu_gnt` / `dma_gnt`  out  1  one-cycle pulse, payload captured this cycle.
- `cpu_rvalid` / `dma_rvalid`  out  1  one-cycle completion pulse (loads and stores).
- `cpu_rdata` / `dma_rdata`  out  32  load result, valid with rvalid; 0 for stores.
- `cpu_rerr` / `dma_rerr`  out  1  illegal access, valid with rvalid.
- `mem_en`  out  1  memory beat this cycle.
- `mem_we`  out  1  beat is a write.
- `mem_addr`  out  MEM_AW  word index.
- `mem_be`  out  4  byte enables; lane k = bits [8k+7:8k], little-endian.
- `mem_wdata`  out  32  lane-shifted write data.
- `mem_rdata`  in  32  read word; valid the cycle after a read beat.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, ACC0, ACC1, WAIT, RESP.
- IDLE, with any req:
  - Arbitrate and pulse the winner's gnt (combinational).
  - Latch id, we, addr, func3 and wdata.
  - Go to ACC0, or to RESP if the access is illegal.
- Arbitration:
  - PRIO_CPU=1: CPU wins ties.
  - PRIO_CPU=0: the requester not granted last wins ties.
  - `last_grant` resets to DMA, so the CPU wins the first tie.
  - Grants occur only in IDLE; requests held during busy are ignored until IDLE.
- Illegal access: func3 ∈ {3,6,7}, or a store with func3 ∈ {4,5}.
  - No memory beat is issued.
  - RESP asserts rvalid with rerr=1 and rdata=0.
- Access geometry: offset o = addr[1:0]; size s = 1/2/4 bytes; w = addr[MEM_AW+1:2].
- Split when o+s > 4.
  - Beat1 index = w+1 modulo 2^MEM_AW, so it wraps to 0 at the top of memory.
- ACC0: mem_en=1, mem_addr=w, mem_be = lanes o..min(3,o+s-1), mem_wdata = wdata << 8o.
  - Next state is ACC1 if split, else WAIT.
- ACC1: mem_en=1, mem_addr=w+1, mem_be = lanes 0..o+s-5, mem_wdata = wdata >> 8(4-o).
  - Capture the beat0 read word. Next state is WAIT.
- WAIT: capture the final read word and assemble the result.
  - Form the 64-bit {word1, word0}, shift right by 8o, take s bytes.
  - Sign-extend for func3 0/1, zero-extend for 4/5.
  - Register rdata and rvalid. Next state is RESP.
- RESP: rvalid/rdata/rerr asserted on the owner's port only. Next state is IDLE.
- Write beats update only enabled lanes; the store rdata output is 0.
- All mem_* outputs are 0 when mem_en=0.

## Timing
- Request accepted (gnt) in cycle T.
- Aligned or error-free non-split access: beat at T+1, rvalid at T+3.
- Split access: beats at T+1 and T+2, rvalid at T+4.
- Illegal access: rvalid at T+1.
- Next grant is possible at T+4 (aligned) or T+5 (split), i.e. in the first IDLE cycle after RESP.
- Reset (rstn low, any time, including mid-split):
  - Takes effect immediately: state IDLE, all outputs 0, last_grant = DMA.
  - The in-flight access is abandoned: no further beat and no rvalid.
  - A partially written split store leaves beat0's lanes written.
- Simultaneous req and rvalid on different ports are independent; gnt is never asserted outside IDLE.

## Test plan
- Aligned load: mem[0x10] = 0xDEADBEEF; CPU lw 0x40 at T.
  - Expect a single beat at T+1 with index 0x10 and be=1111.
  - Expect cpu_rvalid at T+3 with rdata 0xDEADBEEF.
- Byte loads: mem[0x10] = 0x80FF00FF.
  - lb 0x43 → 0xFFFFFF80.
  - lbu 0x43 → 0x00000080.
  - lh 0x41 → 0xFFFFFF00.
- Misaligned load: mem[0x10] = 0x44332211, mem[0x11] = 0x88776655; DMA lw 0x42.
  - Expect beats at index 0x10 then 0x11.
  - Expect dma_rvalid at T+4 with rdata 0x66554433.
- Wrapping split store: sw 0xAABBCCDD to 0xFFD.
  - Beat0: idx 0x3FF, be=1110, wdata 0xBBCCDD00.
  - Beat1: idx 0x000, be=0001, wdata 0x000000AA.
  - rvalid at T+4.
- Arbitration: both requesters hold req continuously.
  - PRIO_CPU=0: grants go CPU, DMA, CPU, DMA.
  - PRIO_CPU=1: every grant goes to the CPU.
  - No gnt is ever asserted while busy=1.
- Error and reset cases:
  - CPU func3=3 → rvalid at T+1 with rerr=1 and no mem_en.
  - rstn low during ACC1 of a split store → outputs 0 the same cycle, no beat1 issued, no rvalid.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundles the two requester ports and the single-ported memory port of dmem_arbiter.
interface dmem_arbiter_if #(
   parameter int unsigned MEM_AW = 10
);
   logic              cpu_req;
   logic              cpu_we;
   logic [31:0]       cpu_addr;
   logic [2:0]        cpu_func3;
   logic [31:0]       cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [31:0]       cpu_rdata;
   logic              cpu_rerr;

   logic              dma_req;
   logic              dma_we;
   logic [31:0]       dma_addr;
   logic [2:0]        dma_func3;
   logic [31:0]       dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [31:0]       dma_rdata;
   logic              dma_rerr;

   logic              mem_en;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              busy;

   // Arbiter side: serves both requesters and drives the memory.
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_func3, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_rerr,
      input  dma_req, dma_we, dma_addr, dma_func3, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata, dma_rerr,
      output mem_en, mem_we, mem_addr, mem_be, mem_wdata, busy,
      input  mem_rdata
   );

   // Environment side: requesters plus the memory itself.
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_func3, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_rerr,
      output dma_req, dma_we, dma_addr, dma_func3, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata, dma_rerr,
      input  mem_en, mem_we, mem_addr, mem_be, mem_wdata, busy,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: grants one access at a time, splits misaligned
// accesses into two aligned word beats and sign/zero-extends load data.
module dmem_arbiter #(
   parameter int unsigned MEM_AW   = 10,
   parameter bit          PRIO_CPU = 1'b0
) (
   input  logic           clk,
   input  logic           rstn,
   dmem_arbiter_if.slave  bus
);
   localparam int unsigned AW = MEM_AW + 2;

   typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, RESP} state_e;

   typedef struct packed {
      logic          id;      // 0 = CPU, 1 = DMA
      logic          we;
      logic [AW-1:0] addr;
      logic [2:0]    func3;
      logic [31:0]   wdata;
   } req_t;

   state_e      state_q, state_d;
   req_t        req_q, req_d;
   logic        last_dma_q, last_dma_d;
   logic [31:0] word0_q, word0_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        rerr_q, rerr_d;

   logic              cpu_gnt_c, dma_gnt_c;
   logic              mem_en_c, mem_we_c;
   logic [MEM_AW-1:0] mem_addr_c;
   logic [3:0]        mem_be_c;
   logic [31:0]       mem_wdata_c;

   // Arbitration: ties go to the CPU under fixed priority or when DMA was granted last.
   logic          cpu_win, dma_win, sel_we, illegal;
   logic [2:0]    sel_f3;
   logic [AW-1:0] sel_addr;
   logic [31:0]   sel_wdata;

   assign cpu_win   = bus.cpu_req & (~bus.dma_req | PRIO_CPU | last_dma_q);
   assign dma_win   = bus.dma_req & ~cpu_win;
   assign sel_we    = dma_win ? bus.dma_we    : bus.cpu_we;
   assign sel_f3    = dma_win ? bus.dma_func3 : bus.cpu_func3;
   assign sel_addr  = dma_win ? bus.dma_addr[AW-1:0] : bus.cpu_addr[AW-1:0];
   assign sel_wdata = dma_win ? bus.dma_wdata : bus.cpu_wdata;
   assign illegal   = (sel_f3 == 3'd3) | (sel_f3[2] & sel_f3[1]) | (sel_we & sel_f3[2]);

   logic unused_addr_hi;
   assign unused_addr_hi = ^{bus.cpu_addr[31:AW], bus.dma_addr[31:AW]};

   // Beat geometry of the latched access: an 8-lane window over {word1, word0}.
   logic [1:0]        off;
   logic [MEM_AW-1:0] widx;
   logic [3:0]        mask;
   logic [7:0]        be8;
   logic              split;
   logic [63:0]       wd64;

   assign off   = req_q.addr[1:0];
   assign widx  = req_q.addr[AW-1:2];
   assign mask  = (req_q.func3[1:0] == 2'd0) ? 4'b0001 :
                  (req_q.func3[1:0] == 2'd1) ? 4'b0011 : 4'b1111;
   assign be8   = 8'({4'b0000, mask} << off);
   assign split = |be8[7:4];
   assign wd64  = 64'(req_q.wdata) << {off, 3'b000};

   // Load assembly from the beat0 word and the word arriving this cycle.
   logic [31:0] word0, word1, sh, ld_data;

   assign word0   = split ? word0_q : bus.mem_rdata;
   assign word1   = split ? bus.mem_rdata : 32'd0;
   assign sh      = 32'({word1, word0} >> {off, 3'b000});
   assign ld_data = (req_q.func3 == 3'd0) ? {{24{sh[7]}}, sh[7:0]}   :
                    (req_q.func3 == 3'd4) ? {24'd0, sh[7:0]}         :
                    (req_q.func3 == 3'd1) ? {{16{sh[15]}}, sh[15:0]} :
                    (req_q.func3 == 3'd5) ? {16'd0, sh[15:0]}        : sh;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         req_q      <= '0;
         last_dma_q <= 1'b1;
         word0_q    <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         rerr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         last_dma_q <= last_dma_d;
         word0_q    <= word0_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         rerr_q     <= rerr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      last_dma_d  = last_dma_q;
      word0_d     = word0_q;
      rdata_d     = '0;
      rvalid_d    = 1'b0;
      rerr_d      = 1'b0;
      cpu_gnt_c   = 1'b0;
      dma_gnt_c   = 1'b0;
      mem_en_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_be_c    = '0;
      mem_wdata_c = '0;

      unique case (state_q)
         IDLE: begin
            if (cpu_win || dma_win) begin
               cpu_gnt_c   = cpu_win;
               dma_gnt_c   = dma_win;
               last_dma_d  = dma_win;
               req_d.id    = dma_win;
               req_d.we    = sel_we;
               req_d.addr  = sel_addr;
               req_d.func3 = sel_f3;
               req_d.wdata = sel_wdata;
               if (illegal) begin
                  state_d  = RESP;
                  rvalid_d = 1'b1;
                  rerr_d   = 1'b1;
               end else begin
                  state_d  = ACC0;
               end
            end
         end
         ACC0: begin
            mem_en_c    = 1'b1;
            mem_we_c    = req_q.we;
            mem_addr_c  = widx;
            mem_be_c    = be8[3:0];
            mem_wdata_c = wd64[31:0];
            state_d     = split ? ACC1 : WAIT;
         end
         ACC1: begin
            // Upper beat wraps to word 0 at the top of memory.
            mem_en_c    = 1'b1;
            mem_we_c    = req_q.we;
            mem_addr_c  = widx + MEM_AW'(1);
            mem_be_c    = be8[7:4];
            mem_wdata_c = wd64[63:32];
            word0_d     = bus.mem_rdata;
            state_d     = WAIT;
         end
         WAIT: begin
            rdata_d  = req_q.we ? 32'd0 : ld_data;
            rvalid_d = 1'b1;
            state_d  = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.cpu_gnt    = cpu_gnt_c;
   assign bus.dma_gnt    = dma_gnt_c;
   assign bus.cpu_rvalid = rvalid_q & ~req_q.id;
   assign bus.dma_rvalid = rvalid_q &  req_q.id;
   assign bus.cpu_rdata  = bus.cpu_rvalid ? rdata_q : 32'd0;
   assign bus.dma_rdata  = bus.dma_rvalid ? rdata_q : 32'd0;
   assign bus.cpu_rerr   = rerr_q & ~req_q.id;
   assign bus.dma_rerr   = rerr_q &  req_q.id;
   assign bus.mem_en     = mem_en_c;
   assign bus.mem_we     = mem_we_c;
   assign bus.mem_addr   = mem_addr_c;
   assign bus.mem_be     = mem_be_c;
   assign bus.mem_wdata  = mem_wdata_c;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance with a byte-lane memory model
// and a CPU-priority instance used only for the arbitration sequence.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.MEM_AW(10)) bus0 ();
   dmem_arbiter_if #(.MEM_AW(10)) bus1 ();

   dmem_arbiter #(.MEM_AW(10), .PRIO_CPU(1'b0)) u_dut0 (.clk(clk), .rstn(rstn), .bus(bus0));
   dmem_arbiter #(.MEM_AW(10), .PRIO_CPU(1'b1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

   // Word memory with byte-lane writes and one-cycle read latency; pre_* is a preload path.
   logic [31:0] mem [1024];
   logic [31:0] rd_q;
   logic        pre_we = 1'b0;
   logic [9:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (bus0.mem_en) begin
         if (bus0.mem_we) begin
            for (int k = 0; k < 4; k++)
               if (bus0.mem_be[k]) mem[bus0.mem_addr][8*k +: 8] <= bus0.mem_wdata[8*k +: 8];
         end else begin
            rd_q <= mem[bus0.mem_addr];
         end
      end
   end
   assign bus0.mem_rdata = rd_q;
   assign bus1.mem_rdata = 32'd0;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   logic [9:0]  bt_idx [2];
   logic [3:0]  bt_be  [2];
   logic [31:0] bt_wd  [2];
   int          bt_cyc [2];

   task automatic poke(input logic [9:0] a, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   // Issues one access on bus0 in the current (idle) cycle T; returns rvalid latency and beats.
   task automatic access(input bit dma, input bit we, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata, output logic rerr,
                         output int nbeats);
      if (dma) begin
         bus0.dma_req = 1'b1; bus0.dma_we = we; bus0.dma_addr = addr;
         bus0.dma_func3 = f3; bus0.dma_wdata = wd;
      end else begin
         bus0.cpu_req = 1'b1; bus0.cpu_we = we; bus0.cpu_addr = addr;
         bus0.cpu_func3 = f3; bus0.cpu_wdata = wd;
      end
      #1;
      chk("gnt", dma ? bus0.dma_gnt : bus0.cpu_gnt, 1);
      lat = 99; rdata = '0; rerr = 1'b0; nbeats = 0;
      for (int i = 1; i <= 10; i++) begin
         if (lat == 99) begin
            @(posedge clk); #1;
            if (i == 1) begin bus0.cpu_req = 1'b0; bus0.dma_req = 1'b0; end
            #1;
            if (bus0.mem_en) begin
               if (nbeats < 2) begin
                  bt_idx[nbeats] = bus0.mem_addr; bt_be[nbeats] = bus0.mem_be;
                  bt_wd[nbeats] = bus0.mem_wdata; bt_cyc[nbeats] = i;
               end
               nbeats++;
            end
            if (dma ? bus0.dma_rvalid : bus0.cpu_rvalid) begin
               lat   = i;
               rdata = dma ? bus0.dma_rdata : bus0.cpu_rdata;
               rerr  = dma ? bus0.dma_rerr : bus0.cpu_rerr;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   int          lat, nb, ng0, ng1, viol, ev;
   logic [31:0] rd;
   logic        re;
   logic [3:0]  seq0, seq1;

   initial begin
      bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = '0; bus0.cpu_func3 = '0; bus0.cpu_wdata = '0;
      bus0.dma_req = 0; bus0.dma_we = 0; bus0.dma_addr = '0; bus0.dma_func3 = '0; bus0.dma_wdata = '0;
      bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_func3 = 3'd2; bus1.cpu_wdata = '0;
      bus1.dma_req = 0; bus1.dma_we = 0; bus1.dma_addr = '0; bus1.dma_func3 = 3'd2; bus1.dma_wdata = '0;

      #12;
      chk("rst_busy", bus0.busy, 0);
      chk("rst_mem_en", bus0.mem_en, 0);
      chk("rst_rvalid", bus0.cpu_rvalid, 0);
      @(posedge clk); #1 rstn = 1'b1;
      @(posedge clk); #1;
      chk("idle_no_gnt", {bus0.cpu_gnt, bus0.dma_gnt}, 0);

      // Aligned word load
      poke(10'h10, 32'hDEADBEEF);
      access(0, 0, 32'h40, 3'd2, '0, lat, rd, re, nb);
      chk("lw_lat", lat, 3);
      chk("lw_rdata", rd, 32'hDEADBEEF);
      chk("lw_rerr", re, 0);
      chk("lw_nbeats", nb, 1);
      chk("lw_beat_cyc", bt_cyc[0], 1);
      chk("lw_beat_idx", bt_idx[0], 10'h10);
      chk("lw_beat_be", bt_be[0], 4'b1111);

      // Byte/halfword loads with extension
      poke(10'h10, 32'h80FF00FF);
      access(0, 0, 32'h43, 3'd0, '0, lat, rd, re, nb);
      chk("lb_rdata", rd, 32'hFFFFFF80);
      access(0, 0, 32'h43, 3'd4, '0, lat, rd, re, nb);
      chk("lbu_rdata", rd, 32'h00000080);
      access(0, 0, 32'h41, 3'd1, '0, lat, rd, re, nb);
      chk("lh_rdata", rd, 32'hFFFFFF00);
      chk("lh_lat", lat, 3);

      // Misaligned word load from the DMA port
      poke(10'h10, 32'h44332211);
      poke(10'h11, 32'h88776655);
      access(1, 0, 32'h42, 3'd2, '0, lat, rd, re, nb);
      chk("mlw_lat", lat, 4);
      chk("mlw_rdata", rd, 32'h66554433);
      chk("mlw_nbeats", nb, 2);
      chk("mlw_idx0", bt_idx[0], 10'h10);
      chk("mlw_idx1", bt_idx[1], 10'h11);
      chk("mlw_cyc1", bt_cyc[1], 2);
      access(1, 0, 32'h42, 3'd5, '0, lat, rd, re, nb);
      chk("lhu_rdata", rd, 32'h00004433);

      // Split store wrapping the top of memory
      poke(10'h3FF, 32'h11223344);
      poke(10'h000, 32'h55667788);
      access(0, 1, 32'hFFD, 3'd2, 32'hAABBCCDD, lat, rd, re, nb);
      chk("sw_lat", lat, 4);
      chk("sw_rdata", rd, 0);
      chk("sw_nbeats", nb, 2);
      chk("sw_idx0", bt_idx[0], 10'h3FF);
      chk("sw_be0", bt_be[0], 4'b1110);
      chk("sw_wd0", bt_wd[0], 32'hBBCCDD00);
      chk("sw_idx1", bt_idx[1], 10'h000);
      chk("sw_be1", bt_be[1], 4'b0001);
      chk("sw_wd1", bt_wd[1], 32'h000000AA);
      access(0, 0, 32'hFFC, 3'd2, '0, lat, rd, re, nb);
      chk("sw_rb_top", rd, 32'hBBCCDD44);
      access(0, 0, 32'h000, 3'd2, '0, lat, rd, re, nb);
      chk("sw_rb_zero", rd, 32'h556677AA);

      // Illegal accesses
      access(0, 0, 32'h40, 3'd3, '0, lat, rd, re, nb);
      chk("ill_lat", lat, 1);
      chk("ill_rerr", re, 1);
      chk("ill_rdata", rd, 0);
      chk("ill_nbeats", nb, 0);
      access(1, 1, 32'h40, 3'd4, 32'h12345678, lat, rd, re, nb);
      chk("ill_sbu_lat", lat, 1);
      chk("ill_sbu_rerr", re, 1);

      // Reset during beat1 of a split store
      poke(10'h20, 32'h0);
      poke(10'h21, 32'h0);
      bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 32'h82;
      bus0.cpu_func3 = 3'd2; bus0.cpu_wdata = 32'h11223344;
      #1 chk("rsts_gnt", bus0.cpu_gnt, 1);
      @(posedge clk); #1 bus0.cpu_req = 1'b0;
      #1 chk("rsts_acc0_idx", {bus0.mem_en, bus0.mem_addr}, {1'b1, 10'h20});
      @(posedge clk); #2;
      chk("rsts_acc1_idx", {bus0.mem_en, bus0.mem_addr}, {1'b1, 10'h21});
      rstn = 1'b0;
      #1;
      chk("rsts_out_zero", {bus0.mem_en, bus0.mem_we, bus0.mem_be, bus0.mem_wdata,
                            bus0.busy, bus0.cpu_rvalid}, 0);
      @(posedge clk); #1 rstn = 1'b1;
      ev = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (bus0.mem_en || bus0.cpu_rvalid || bus0.busy) ev++;
         @(posedge clk); #1;
      end
      chk("rsts_quiet", ev, 0);
      access(0, 0, 32'h80, 3'd2, '0, lat, rd, re, nb);
      chk("rsts_beat0_kept", rd, 32'h33440000);
      access(0, 0, 32'h84, 3'd2, '0, lat, rd, re, nb);
      chk("rsts_beat1_none", rd, 32'h0);

      // Arbitration with both requesters holding req
      do_reset();
      bus0.cpu_we = 0; bus0.cpu_addr = 32'h0; bus0.cpu_func3 = 3'd2;
      bus0.dma_we = 0; bus0.dma_addr = 32'h4; bus0.dma_func3 = 3'd2;
      bus0.cpu_req = 1; bus0.dma_req = 1; bus1.cpu_req = 1; bus1.dma_req = 1;
      ng0 = 0; ng1 = 0; viol = 0; seq0 = '0; seq1 = '0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if ((bus0.cpu_gnt || bus0.dma_gnt) && bus0.busy) viol++;
         if ((bus1.cpu_gnt || bus1.dma_gnt) && bus1.busy) viol++;
         if ((bus0.cpu_gnt && bus0.dma_gnt) || (bus1.cpu_gnt && bus1.dma_gnt)) viol++;
         if (bus0.cpu_gnt || bus0.dma_gnt) begin
            if (ng0 < 4) seq0[ng0] = bus0.dma_gnt;
            ng0++;
         end
         if (bus1.cpu_gnt || bus1.dma_gnt) begin
            if (ng1 < 4) seq1[ng1] = bus1.dma_gnt;
            ng1++;
         end
         @(posedge clk); #1;
      end
      bus0.cpu_req = 0; bus0.dma_req = 0; bus1.cpu_req = 0; bus1.dma_req = 0;
      chk("rr_seq", seq0, 4'b1010);
      chk("rr_count", ng0, 5);
      chk("prio_seq", seq1, 4'b0000);
      chk("prio_count", ng1, 5);
      chk("gnt_while_busy", viol, 0);

      repeat (4) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
